// File: rtl/regwb_ctrl_if.sv
// regwb_ctrl_if: bundle of the writeback controller's handshake, register-file
// write port and scoreboard query signals.
// Optional macro REGWB_BYPASS_EN adds the o_rs1_fwd/o_rs2_fwd forwarding data.
interface regwb_ctrl_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  logic          i_flush;
  logic          i_iss_valid;
  logic [AW-1:0] i_iss_rd;
  logic          i_exu_valid;
  logic          o_exu_ready;
  logic [AW-1:0] i_exu_rd;
  logic [DW-1:0] i_exu_data;
  logic          i_lsu_valid;
  logic          o_lsu_ready;
  logic [AW-1:0] i_lsu_rd;
  logic [DW-1:0] i_lsu_data;
  logic          o_wen;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic [AW-1:0] i_rs1;
  logic [AW-1:0] i_rs2;
  logic          o_rs1_busy;
  logic          o_rs2_busy;
`ifdef REGWB_BYPASS_EN
  logic [DW-1:0] o_rs1_fwd;
  logic [DW-1:0] o_rs2_fwd;
`endif

  // Controller side
  modport slave (
    input  i_flush, i_iss_valid, i_iss_rd,
    input  i_exu_valid, i_exu_rd, i_exu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  i_rs1, i_rs2,
    output o_exu_ready, o_lsu_ready,
    output o_wen, o_waddr, o_wdata,
    output o_rs1_busy, o_rs2_busy
`ifdef REGWB_BYPASS_EN
    , output o_rs1_fwd, o_rs2_fwd
`endif
  );

  // Producer / decode side
  modport master (
    output i_flush, i_iss_valid, i_iss_rd,
    output i_exu_valid, i_exu_rd, i_exu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    output i_rs1, i_rs2,
    input  o_exu_ready, o_lsu_ready,
    input  o_wen, o_waddr, o_wdata,
    input  o_rs1_busy, o_rs2_busy
`ifdef REGWB_BYPASS_EN
    , input o_rs1_fwd, o_rs2_fwd
`endif
  );
endinterface

// File: rtl/regwb_ctrl.sv
// regwb_ctrl: writeback controller for the integer register file write port.
// Two 1-entry skid buffers (EXU, LSU), fixed LSU-over-EXU arbitration, and a
// per-register pending-write scoreboard for decode RAW checks.
// Optional macro REGWB_BYPASS_EN: same-cycle forwarding of the write in flight.
module regwb_ctrl #(
  parameter int DW   = 64,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  regwb_ctrl_if.slave bus
);

  logic          exu_vld_q, exu_vld_d;
  logic [AW-1:0] exu_rd_q, exu_rd_d;
  logic [DW-1:0] exu_data_q, exu_data_d;
  logic          lsu_vld_q, lsu_vld_d;
  logic [AW-1:0] lsu_rd_q, lsu_rd_d;
  logic [DW-1:0] lsu_data_q, lsu_data_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic          sel_lsu, sel_exu;
  logic          exu_ready, lsu_ready;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          rs1_busy, rs2_busy;
  logic          exu_acc, lsu_acc;

  // Arbitration: LSU buffer beats EXU buffer; the winner drains this cycle
  always_comb begin
    sel_lsu   = lsu_vld_q;
    sel_exu   = exu_vld_q & ~lsu_vld_q;
    waddr     = '0;
    wdata     = '0;
    if (sel_lsu) begin
      waddr = lsu_rd_q;
      wdata = lsu_data_q;
    end else if (sel_exu) begin
      waddr = exu_rd_q;
      wdata = exu_data_q;
    end
    // Writes to x0 drain the buffer without touching the register file
    wen       = (sel_lsu | sel_exu) & (waddr != '0);
    exu_ready = ~exu_vld_q | sel_exu;
    lsu_ready = ~lsu_vld_q | sel_lsu;
    exu_acc   = bus.i_exu_valid & exu_ready;
    lsu_acc   = bus.i_lsu_valid & lsu_ready;
  end

  // Skid buffer next state: flush empties, accept loads, drain empties
  always_comb begin
    exu_vld_d  = exu_vld_q;
    exu_rd_d   = exu_rd_q;
    exu_data_d = exu_data_q;
    lsu_vld_d  = lsu_vld_q;
    lsu_rd_d   = lsu_rd_q;
    lsu_data_d = lsu_data_q;
    if (sel_exu) exu_vld_d = 1'b0;
    if (sel_lsu) lsu_vld_d = 1'b0;
    if (exu_acc) begin
      exu_vld_d  = 1'b1;
      exu_rd_d   = bus.i_exu_rd;
      exu_data_d = bus.i_exu_data;
    end
    if (lsu_acc) begin
      lsu_vld_d  = 1'b1;
      lsu_rd_d   = bus.i_lsu_rd;
      lsu_data_d = bus.i_lsu_data;
    end
    if (bus.i_flush) begin
      exu_vld_d = 1'b0;
      lsu_vld_d = 1'b0;
    end
  end

  // Scoreboard next state per register: flush, then younger issue over write clear
  assign busy_d[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    always_comb begin
      busy_d[gi] = busy_q[gi];
      if (wen && waddr == AW'(gi))
        busy_d[gi] = 1'b0;
      if (bus.i_iss_valid && bus.i_iss_rd == AW'(gi))
        busy_d[gi] = 1'b1;
      if (bus.i_flush)
        busy_d[gi] = 1'b0;
    end
  end

  // Scoreboard query from the registered busy bits
  always_comb begin
    rs1_busy = busy_q[bus.i_rs1];
    rs2_busy = busy_q[bus.i_rs2];
`ifdef REGWB_BYPASS_EN
    bus.o_rs1_fwd = '0;
    bus.o_rs2_fwd = '0;
    // wen already excludes x0, so a match here is never register 0
    if (wen && waddr == bus.i_rs1) begin
      rs1_busy      = 1'b0;
      bus.o_rs1_fwd = wdata;
    end
    if (wen && waddr == bus.i_rs2) begin
      rs2_busy      = 1'b0;
      bus.o_rs2_fwd = wdata;
    end
`endif
  end

  // State registers; reset drops any buffered result without writing it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exu_vld_q  <= 1'b0;
      exu_rd_q   <= '0;
      exu_data_q <= '0;
      lsu_vld_q  <= 1'b0;
      lsu_rd_q   <= '0;
      lsu_data_q <= '0;
      busy_q     <= '0;
    end else begin
      exu_vld_q  <= exu_vld_d;
      exu_rd_q   <= exu_rd_d;
      exu_data_q <= exu_data_d;
      lsu_vld_q  <= lsu_vld_d;
      lsu_rd_q   <= lsu_rd_d;
      lsu_data_q <= lsu_data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_exu_ready = exu_ready;
  assign bus.o_lsu_ready = lsu_ready;
  assign bus.o_wen       = wen;
  assign bus.o_waddr     = waddr;
  assign bus.o_wdata     = wdata;
  assign bus.o_rs1_busy  = rs1_busy;
  assign bus.o_rs2_busy  = rs2_busy;

endmodule

// File: tb/tb_regwb_ctrl.sv
// tb_regwb_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model of the writeback controller.
module tb_regwb_ctrl;
  localparam int DW   = 64;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regwb_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  regwb_ctrl #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic drive_idle();
    bus.i_flush     = 1'b0;
    bus.i_iss_valid = 1'b0;
    bus.i_iss_rd    = '0;
    bus.i_exu_valid = 1'b0;
    bus.i_exu_rd    = '0;
    bus.i_exu_data  = '0;
    bus.i_lsu_valid = 1'b0;
    bus.i_lsu_rd    = '0;
    bus.i_lsu_data  = '0;
    bus.i_rs1       = '0;
    bus.i_rs2       = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd1; bus.i_exu_data = 64'h1;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd2; bus.i_lsu_data = 64'h2;
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd3;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %0b want 0", bus.o_wen); end
    n_cmp++; if (bus.o_waddr !== '0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", bus.o_waddr); end
    n_cmp++; if (bus.o_wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", bus.o_wdata); end
    n_cmp++; if (bus.o_exu_ready !== 1'b1) begin n_err++; $display("FAIL reset_exu_ready: got %0b want 1", bus.o_exu_ready); end
    n_cmp++; if (bus.o_lsu_ready !== 1'b1) begin n_err++; $display("FAIL reset_lsu_ready: got %0b want 1", bus.o_lsu_ready); end
    drive_idle();
    for (int r = 0; r < NREG; r++) begin
      bus.i_rs1 = AW'(r);
      #1;
      n_cmp++; if (bus.o_rs1_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy r%0d: got %0b want 0", r, bus.o_rs1_busy); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL reset_idle_wen c%0d: got %0b want 0", c, bus.o_wen); end
      @(negedge clk);
    end
    $display("reset: done");
  endtask

  task automatic test_single_exu();
    drive_idle();
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd5; bus.i_rs1 = 5'd5;
    #1;
    n_cmp++; if (bus.o_rs1_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_pre: got %0b want 0", bus.o_rs1_busy); end
    @(negedge clk);
    bus.i_iss_valid = 1'b0;
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd5; bus.i_exu_data = 64'hDEAD_BEEF;
    #1;
    n_cmp++; if (bus.o_rs1_busy !== 1'b1) begin n_err++; $display("FAIL single_busy_set: got %0b want 1", bus.o_rs1_busy); end
    n_cmp++; if (bus.o_exu_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %0b want 1", bus.o_exu_ready); end
    n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL single_wen_early: got %0b want 0", bus.o_wen); end
    @(negedge clk);
    bus.i_exu_valid = 1'b0;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd5 || bus.o_wdata !== 64'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_write: got wen=%0b addr=%0d data=%h want 1/5/deadbeef", bus.o_wen, bus.o_waddr, bus.o_wdata); end
`ifdef REGWB_BYPASS_EN
    n_cmp++; if (bus.o_rs1_busy !== 1'b0 || bus.o_rs1_fwd !== 64'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_bypass: got busy=%0b fwd=%h want 0/deadbeef", bus.o_rs1_busy, bus.o_rs1_fwd); end
`else
    n_cmp++; if (bus.o_rs1_busy !== 1'b1) begin n_err++; $display("FAIL single_busy_wcycle: got %0b want 1", bus.o_rs1_busy); end
`endif
    $display("single_exu: write r%0d = %h", bus.o_waddr, bus.o_wdata);
    @(negedge clk);
    #1;
    n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL single_wen_after: got %0b want 0", bus.o_wen); end
    n_cmp++; if (bus.o_rs1_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_clear: got %0b want 0", bus.o_rs1_busy); end
    @(negedge clk);
  endtask

  task automatic test_collision();
    drive_idle();
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd3; bus.i_exu_data = 64'h11;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd4; bus.i_lsu_data = 64'h22;
    @(negedge clk);
    bus.i_lsu_valid = 1'b0;
    bus.i_exu_rd = 5'd6; bus.i_exu_data = 64'h33;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd4 || bus.o_wdata !== 64'h22) begin
      n_err++; $display("FAIL coll_first: got wen=%0b addr=%0d data=%h want 1/4/22", bus.o_wen, bus.o_waddr, bus.o_wdata); end
    n_cmp++; if (bus.o_exu_ready !== 1'b0) begin n_err++; $display("FAIL coll_exu_stall: got %0b want 0", bus.o_exu_ready); end
    $display("collision: write r%0d = %h", bus.o_waddr, bus.o_wdata);
    @(negedge clk);
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd3 || bus.o_wdata !== 64'h11) begin
      n_err++; $display("FAIL coll_second: got wen=%0b addr=%0d data=%h want 1/3/11", bus.o_wen, bus.o_waddr, bus.o_wdata); end
    n_cmp++; if (bus.o_exu_ready !== 1'b1) begin n_err++; $display("FAIL coll_exu_resume: got %0b want 1", bus.o_exu_ready); end
    $display("collision: write r%0d = %h", bus.o_waddr, bus.o_wdata);
    @(negedge clk);
    bus.i_exu_valid = 1'b0;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd6 || bus.o_wdata !== 64'h33) begin
      n_err++; $display("FAIL coll_third: got wen=%0b addr=%0d data=%h want 1/6/33", bus.o_wen, bus.o_waddr, bus.o_wdata); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL coll_idle: got %0b want 0", bus.o_wen); end
    @(negedge clk);
  endtask

  task automatic test_x0();
    drive_idle();
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd0; bus.i_lsu_data = 64'hFFFF;
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd2; bus.i_exu_data = 64'h5;
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd0;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL x0_wen: got %0b want 0", bus.o_wen); end
    n_cmp++; if (bus.o_rs1_busy !== 1'b0) begin n_err++; $display("FAIL x0_busy: got %0b want 0", bus.o_rs1_busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd2 || bus.o_wdata !== 64'h5) begin
      n_err++; $display("FAIL x0_drained: got wen=%0b addr=%0d data=%h want 1/2/5", bus.o_wen, bus.o_waddr, bus.o_wdata); end
    $display("x0: write r%0d = %h after x0 drain", bus.o_waddr, bus.o_wdata);
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    drive_idle();
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd7;
    @(negedge clk);
    bus.i_iss_valid = 1'b0;
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd7; bus.i_exu_data = 64'h77;
    @(negedge clk);
    bus.i_exu_valid = 1'b0;
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd7; bus.i_rs1 = 5'd7;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd7) begin
      n_err++; $display("FAIL same_write: got wen=%0b addr=%0d want 1/7", bus.o_wen, bus.o_waddr); end
    @(negedge clk);
    bus.i_iss_valid = 1'b0;
    #1;
    n_cmp++; if (bus.o_rs1_busy !== 1'b1) begin n_err++; $display("FAIL same_set_wins: got %0b want 1", bus.o_rs1_busy); end
    $display("same_cycle: r7 busy=%0b after overlapping issue", bus.o_rs1_busy);
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd7; bus.i_exu_data = 64'h78;
    @(negedge clk);
    bus.i_exu_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.o_rs1_busy !== 1'b0) begin n_err++; $display("FAIL same_cleanup: got %0b want 0", bus.o_rs1_busy); end
    @(negedge clk);
  endtask

  task automatic test_bypass_flush();
    drive_idle();
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd9;
    @(negedge clk);
    bus.i_iss_valid = 1'b0;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd9; bus.i_lsu_data = 64'h42; bus.i_rs2 = 5'd9;
    #1;
    n_cmp++; if (bus.o_rs2_busy !== 1'b1) begin n_err++; $display("FAIL byp_busy_pre: got %0b want 1", bus.o_rs2_busy); end
    @(negedge clk);
    bus.i_lsu_valid = 1'b0;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd9) begin
      n_err++; $display("FAIL byp_write: got wen=%0b addr=%0d want 1/9", bus.o_wen, bus.o_waddr); end
`ifdef REGWB_BYPASS_EN
    n_cmp++; if (bus.o_rs2_busy !== 1'b0 || bus.o_rs2_fwd !== 64'h42) begin
      n_err++; $display("FAIL byp_fwd: got busy=%0b fwd=%h want 0/42", bus.o_rs2_busy, bus.o_rs2_fwd); end
`else
    n_cmp++; if (bus.o_rs2_busy !== 1'b1) begin n_err++; $display("FAIL byp_busy_wcycle: got %0b want 1", bus.o_rs2_busy); end
`endif
    @(negedge clk);
    #1;
    n_cmp++; if (bus.o_rs2_busy !== 1'b0) begin n_err++; $display("FAIL byp_busy_after: got %0b want 0", bus.o_rs2_busy); end
`ifdef REGWB_BYPASS_EN
    n_cmp++; if (bus.o_rs2_fwd !== '0) begin n_err++; $display("FAIL byp_fwd_after: got %h want 0", bus.o_rs2_fwd); end
`endif
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd10;
    @(negedge clk);
    bus.i_iss_rd = 5'd11;
    @(negedge clk);
    bus.i_iss_valid = 1'b0;
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd10; bus.i_exu_data = 64'hA;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd11; bus.i_lsu_data = 64'hB;
    @(negedge clk);
    bus.i_exu_rd = 5'd12; bus.i_exu_data = 64'hC;
    bus.i_lsu_rd = 5'd13; bus.i_lsu_data = 64'hD;
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd14;
    bus.i_flush = 1'b1;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd11 || bus.o_wdata !== 64'hB) begin
      n_err++; $display("FAIL flush_inflight: got wen=%0b addr=%0d data=%h want 1/11/b", bus.o_wen, bus.o_waddr, bus.o_wdata); end
    @(negedge clk);
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL flush_nowrite c%0d: got wen=%0b addr=%0d", c, bus.o_wen, bus.o_waddr); end
      @(negedge clk);
    end
    for (int r = 0; r < NREG; r++) begin
      bus.i_rs1 = AW'(r);
      #1;
      n_cmp++; if (bus.o_rs1_busy !== 1'b0) begin n_err++; $display("FAIL flush_busy r%0d: got %0b want 0", r, bus.o_rs1_busy); end
    end
    @(negedge clk);
    $display("bypass_flush: done");
  endtask

  task automatic test_reset_midop();
    drive_idle();
    bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd20; bus.i_rs1 = 5'd20;
    bus.i_exu_valid = 1'b1; bus.i_exu_rd = 5'd1; bus.i_exu_data = 64'h1;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd2; bus.i_lsu_data = 64'h2;
    @(negedge clk);
    drive_idle();
    bus.i_rs1 = 5'd20;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd2) begin
      n_err++; $display("FAIL midrst_pre: got wen=%0b addr=%0d want 1/2", bus.o_wen, bus.o_waddr); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL midrst_wen: got %0b want 0", bus.o_wen); end
    n_cmp++; if (bus.o_exu_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %0b want 1", bus.o_exu_ready); end
    n_cmp++; if (bus.o_rs1_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b want 0", bus.o_rs1_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.o_wen !== 1'b0) begin n_err++; $display("FAIL midrst_dropped: got %0b want 0", bus.o_wen); end
    @(negedge clk);
    $display("reset_midop: done");
  endtask

  task automatic test_random();
    ent_t exu_q[$];
    ent_t lsu_q[$];
    bit   mbusy[NREG];
    ent_t w;
    bit   has_w, w_lsu, e_wen, e_exu_rdy, e_lsu_rdy, exu_hold, lsu_hold;
    bit   e_b1, e_b2, exu_acc, lsu_acc, iss;
    logic [AW-1:0] iss_rd;
    logic [DW-1:0] e_f1, e_f2;
    int   n_wr;
    for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
    exu_hold = 1'b0; lsu_hold = 1'b0; n_wr = 0;
    drive_idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Expected write this cycle: oldest pending LSU result, else EXU result
      has_w = (lsu_q.size() > 0) || (exu_q.size() > 0);
      w_lsu = lsu_q.size() > 0;
      w     = w_lsu ? lsu_q[0] : (exu_q.size() > 0 ? exu_q[0] : '0);
      e_wen = has_w && (w.rd != 0);
      e_exu_rdy = (exu_q.size() == 0) || (has_w && !w_lsu);
      e_lsu_rdy = (lsu_q.size() == 0) || w_lsu;

      if (!exu_hold) begin
        bus.i_exu_valid = ($urandom_range(0, 9) < 6);
        bus.i_exu_rd    = AW'($urandom_range(0, NREG - 1));
        bus.i_exu_data  = {$urandom, $urandom};
      end
      if (!lsu_hold) begin
        bus.i_lsu_valid = ($urandom_range(0, 9) < 4);
        bus.i_lsu_rd    = AW'($urandom_range(0, NREG - 1));
        bus.i_lsu_data  = {$urandom, $urandom};
      end
      iss_rd = AW'($urandom_range(0, NREG - 1));
      iss    = ($urandom_range(0, 2) == 0) && !(mbusy[iss_rd] && !(e_wen && w.rd == iss_rd));
      bus.i_iss_valid = iss;
      bus.i_iss_rd    = iss_rd;
      bus.i_flush     = ($urandom_range(0, 39) == 0);
      bus.i_rs1 = (has_w && $urandom_range(0, 2) == 0) ? w.rd : AW'($urandom_range(0, NREG - 1));
      bus.i_rs2 = (has_w && $urandom_range(0, 2) == 0) ? w.rd : AW'($urandom_range(0, NREG - 1));

      e_b1 = mbusy[bus.i_rs1];
      e_b2 = mbusy[bus.i_rs2];
      e_f1 = '0;
      e_f2 = '0;
`ifdef REGWB_BYPASS_EN
      if (e_wen && w.rd == bus.i_rs1) begin e_b1 = 1'b0; e_f1 = w.data; end
      if (e_wen && w.rd == bus.i_rs2) begin e_b2 = 1'b0; e_f2 = w.data; end
`endif
      #1;
      n_cmp++; if (bus.o_exu_ready !== e_exu_rdy) begin n_err++; $display("FAIL rnd_exu_ready cyc%0d: got %0b want %0b", cyc, bus.o_exu_ready, e_exu_rdy); end
      n_cmp++; if (bus.o_lsu_ready !== e_lsu_rdy) begin n_err++; $display("FAIL rnd_lsu_ready cyc%0d: got %0b want %0b", cyc, bus.o_lsu_ready, e_lsu_rdy); end
      n_cmp++; if (bus.o_wen !== e_wen) begin n_err++; $display("FAIL rnd_wen cyc%0d: got %0b want %0b", cyc, bus.o_wen, e_wen); end
      if (has_w) begin
        n_cmp++; if (bus.o_waddr !== w.rd || bus.o_wdata !== w.data) begin
          n_err++; $display("FAIL rnd_wdata cyc%0d: got r%0d=%h want r%0d=%h", cyc, bus.o_waddr, bus.o_wdata, w.rd, w.data); end
      end
      n_cmp++; if (bus.o_rs1_busy !== e_b1) begin n_err++; $display("FAIL rnd_rs1_busy cyc%0d r%0d: got %0b want %0b", cyc, bus.i_rs1, bus.o_rs1_busy, e_b1); end
      n_cmp++; if (bus.o_rs2_busy !== e_b2) begin n_err++; $display("FAIL rnd_rs2_busy cyc%0d r%0d: got %0b want %0b", cyc, bus.i_rs2, bus.o_rs2_busy, e_b2); end
`ifdef REGWB_BYPASS_EN
      n_cmp++; if (bus.o_rs1_fwd !== e_f1 || bus.o_rs2_fwd !== e_f2) begin
        n_err++; $display("FAIL rnd_fwd cyc%0d: got %h/%h want %h/%h", cyc, bus.o_rs1_fwd, bus.o_rs2_fwd, e_f1, e_f2); end
`endif
      if (e_wen) begin
        n_wr++;
        $display("rnd: cyc %0d write r%0d = %h (%s)", cyc, w.rd, w.data, w_lsu ? "lsu" : "exu");
      end

      // Advance the model across the clock edge
      exu_acc = bus.i_exu_valid && e_exu_rdy;
      lsu_acc = bus.i_lsu_valid && e_lsu_rdy;
      if (has_w) begin
        if (w_lsu) void'(lsu_q.pop_front());
        else       void'(exu_q.pop_front());
      end
      if (e_wen) mbusy[w.rd] = 1'b0;
      if (bus.i_flush) begin
        exu_q.delete();
        lsu_q.delete();
        for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
      end else begin
        if (exu_acc) exu_q.push_back('{rd: bus.i_exu_rd, data: bus.i_exu_data});
        if (lsu_acc) lsu_q.push_back('{rd: bus.i_lsu_rd, data: bus.i_lsu_data});
        if (iss && iss_rd != 0) mbusy[iss_rd] = 1'b1;
      end
      exu_hold = bus.i_exu_valid && !exu_acc && !bus.i_flush;
      lsu_hold = bus.i_lsu_valid && !lsu_acc && !bus.i_flush;
      @(negedge clk);
    end
    drive_idle();
    $display("random: %0d register writes observed", n_wr);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_exu();
    test_collision();
    test_x0();
    test_same_cycle();
    test_bypass_flush();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
